// File: rtl/accel_seq_pkg.sv
// Shared types and bit positions for the accel_sequencer control slice
// (state encoding, status/error bit indices, row width).
package accel_seq_pkg;

  localparam int ROW_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_W  = 2'd1,
    ST_READY   = 2'd2,
    ST_COMPUTE = 2'd3
  } state_t;

  localparam int STATUS_OUT_VALID = 0;
  localparam int STATUS_BUSY      = 1;
  localparam int STATUS_LOADED    = 2;
  localparam int STATUS_IN_FULL   = 3;
  localparam int STATUS_IN_EMPTY  = 4;
  localparam int STATUS_STATE_LSB = 5;

  localparam int ERR_IN_OVF       = 0;
  localparam int ERR_HS_EMPTY     = 1;
  localparam int ERR_W_IN_COMPUTE = 8;
  localparam int ERR_START_BAD    = 9;
  localparam int ERR_OUT_OVF      = 10;

endpackage

// File: rtl/accel_sequencer_sync_fifo.sv
// Synchronous FIFO with flush; head is visible on dout while non-empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
  import accel_seq_pkg::*;
#(
  parameter int WIDTH = ROW_W,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy update; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/accel_sequencer.sv
// Sequencer between the bus register front-end and the MAC array: weight load,
// input buffering, credit-limited issue, result buffering. Optional macro ACCEL_SEQ_PERF_CNT_EN adds perf_cycles.
module accel_sequencer
  import accel_seq_pkg::*;
#(
  parameter int ARRAY_DIM = 8,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         wr_en_push,
  input  logic                         is_weight,
  input  logic [ROW_W-1:0]             write_data,
  input  logic [7:0]                   ctrl_reg,
  input  logic                         handshake,
  input  logic                         arr_out_valid,
  input  logic [ROW_W-1:0]             arr_out_data,
  output logic                         w_load,
  output logic [$clog2(ARRAY_DIM)-1:0] w_row,
  output logic [ROW_W-1:0]             w_data,
  output logic                         arr_in_valid,
  output logic [ROW_W-1:0]             arr_in_data,
  output logic [ROW_W-1:0]             output_data,
  output logic [7:0]                   status_reg,
  output logic [15:0]                  err_reg
`ifdef ACCEL_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_cycles
`endif
);

  localparam int RW = $clog2(ARRAY_DIM);
  localparam int IC = $clog2(IN_DEPTH) + 1;
  localparam int OC = $clog2(OUT_DEPTH) + 1;
  localparam int CW = OC + 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ARRAY_DIM - 1);

  state_t            state_q, state_d;
  logic [RW-1:0]     row_cnt_q, row_cnt_d, w_row_q, w_row_d;
  logic              weights_loaded_q, weights_loaded_d, start_q, start_d;
  logic [OC-1:0]     in_flight_q, in_flight_d, drain_q, drain_d, pending;
  logic [15:0]       err_q, err_d;
  logic [7:0]        status_q, status_d;
  logic              w_load_q, w_load_d, arr_in_valid_q, arr_in_valid_d;
  logic [ROW_W-1:0]  w_data_q, w_data_d, arr_in_data_q, arr_in_data_d;

  logic [ROW_W-1:0]  in_head, out_head;
  logic              in_full, in_empty, out_full, out_empty;
  logic [IC-1:0]     in_count_unused;
  logic [OC-1:0]     out_count;
  logic [CW-1:0]     credit_used;
  logic              flush, start_edge, w_push, in_push, issue, draining, res_push, res_pop;
  logic              ctrl_unused;

  assign flush       = ctrl_reg[1];
  assign ctrl_unused = ^ctrl_reg[7:2];
  assign start_edge  = ctrl_reg[0] & ~start_q;
  assign w_push      = wr_en_push & is_weight;
  assign in_push     = wr_en_push & ~is_weight;
  assign credit_used = CW'(in_flight_q) + CW'(out_count);
  assign issue       = (state_q == ST_COMPUTE) & ~in_empty & (credit_used < CW'(OUT_DEPTH)) & ~flush;
  assign draining    = (drain_q != '0);
  // Results owed to a cleared computation are swallowed, never buffered.
  assign res_push    = arr_out_valid & ~draining & ~out_full;
  assign res_pop     = handshake & ~out_empty;
  assign pending     = drain_q + in_flight_q;

  sync_fifo #(.WIDTH(ROW_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .n_rst(n_rst), .flush(flush), .push(in_push), .pop(issue),
    .din(write_data), .dout(in_head), .full(in_full), .empty(in_empty), .count(in_count_unused)
  );

  sync_fifo #(.WIDTH(ROW_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk(clk), .n_rst(n_rst), .flush(flush), .push(res_push), .pop(res_pop),
    .din(arr_out_data), .dout(out_head), .full(out_full), .empty(out_empty), .count(out_count)
  );

  // Next-state, counters, sticky errors and registered array-side strobes.
  always_comb begin
    state_d          = state_q;
    row_cnt_d        = row_cnt_q;
    weights_loaded_d = weights_loaded_q;
    start_d          = ctrl_reg[0];
    in_flight_d      = in_flight_q;
    drain_d          = drain_q;
    err_d            = err_q;
    w_load_d         = 1'b0;
    w_row_d          = '0;
    w_data_d         = '0;
    arr_in_valid_d   = 1'b0;
    arr_in_data_d    = '0;
    if (flush) begin
      state_d          = ST_IDLE;
      row_cnt_d        = '0;
      weights_loaded_d = 1'b0;
      in_flight_d      = '0;
      err_d            = '0;
      drain_d          = (arr_out_valid && pending != '0) ? pending - OC'(1) : pending;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_push) begin
            w_load_d  = 1'b1;
            w_data_d  = write_data;
            row_cnt_d = RW'(1);
            state_d   = ST_LOAD_W;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD_W: begin
          if (w_push) begin
            w_load_d = 1'b1;
            w_row_d  = row_cnt_q;
            w_data_d = write_data;
            if (row_cnt_q == LAST_ROW) begin
              row_cnt_d        = '0;
              weights_loaded_d = 1'b1;
              state_d          = ST_READY;
            end else begin
              row_cnt_d = row_cnt_q + RW'(1);
            end
          end else begin
            state_d = ST_LOAD_W;
          end
        end
        ST_READY: begin
          if (start_edge) begin
            state_d = ST_COMPUTE;
          end else if (w_push) begin
            w_load_d         = 1'b1;
            w_data_d         = write_data;
            row_cnt_d        = RW'(1);
            weights_loaded_d = 1'b0;
            state_d          = ST_LOAD_W;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_COMPUTE: begin
          if (in_empty && in_flight_q == '0) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_COMPUTE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      case ({issue, arr_out_valid & ~draining})
        2'b10:   in_flight_d = in_flight_q + OC'(1);
        2'b01:   in_flight_d = (in_flight_q != '0) ? in_flight_q - OC'(1) : in_flight_q;
        default: in_flight_d = in_flight_q;
      endcase
      drain_d        = (arr_out_valid && draining) ? drain_q - OC'(1) : drain_q;
      arr_in_valid_d = issue;
      arr_in_data_d  = issue ? in_head : '0;

      err_d[ERR_IN_OVF]       = err_q[ERR_IN_OVF] | (in_push & in_full & ~issue);
      err_d[ERR_HS_EMPTY]     = err_q[ERR_HS_EMPTY] | (handshake & out_empty);
      err_d[ERR_W_IN_COMPUTE] = err_q[ERR_W_IN_COMPUTE] |
                                (w_push & ((state_q == ST_COMPUTE) | ((state_q == ST_READY) & start_edge)));
      err_d[ERR_START_BAD]    = err_q[ERR_START_BAD] | (start_edge & (state_q != ST_READY));
      err_d[ERR_OUT_OVF]      = err_q[ERR_OUT_OVF] | (arr_out_valid & ~draining & out_full);
    end
  end

  // Status snapshot, registered so it reads all-zero straight out of reset.
  always_comb begin
    status_d                        = 8'h00;
    status_d[STATUS_OUT_VALID]      = (out_count != '0);
    status_d[STATUS_BUSY]           = (state_q == ST_COMPUTE);
    status_d[STATUS_LOADED]         = weights_loaded_q;
    status_d[STATUS_IN_FULL]        = in_full;
    status_d[STATUS_IN_EMPTY]       = in_empty;
    status_d[STATUS_STATE_LSB +: 2] = state_q;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q          <= ST_IDLE;
      row_cnt_q        <= '0;
      weights_loaded_q <= 1'b0;
      start_q          <= 1'b0;
      in_flight_q      <= '0;
      drain_q          <= '0;
      err_q            <= '0;
      status_q         <= '0;
      w_load_q         <= 1'b0;
      w_row_q          <= '0;
      w_data_q         <= '0;
      arr_in_valid_q   <= 1'b0;
      arr_in_data_q    <= '0;
    end else begin
      state_q          <= state_d;
      row_cnt_q        <= row_cnt_d;
      weights_loaded_q <= weights_loaded_d;
      start_q          <= start_d;
      in_flight_q      <= in_flight_d;
      drain_q          <= drain_d;
      err_q            <= err_d;
      status_q         <= status_d;
      w_load_q         <= w_load_d;
      w_row_q          <= w_row_d;
      w_data_q         <= w_data_d;
      arr_in_valid_q   <= arr_in_valid_d;
      arr_in_data_q    <= arr_in_data_d;
    end
  end

  assign w_load       = w_load_q;
  assign w_row        = w_row_q;
  assign w_data       = w_data_q;
  assign arr_in_valid = arr_in_valid_q;
  assign arr_in_data  = arr_in_data_q;
  assign output_data  = out_empty ? '0 : out_head;
  assign status_reg   = status_q;
  assign err_reg      = err_q;

`ifdef ACCEL_SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Saturating COMPUTE-cycle counter, restarted by clear and accepted starts.
  always_comb begin
    perf_d = perf_q;
    if (flush || (start_edge && state_q == ST_READY)) begin
      perf_d = 32'd0;
    end else if (state_q == ST_COMPUTE && perf_q != 32'hFFFF_FFFF) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Performance counter register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_accel_sequencer.sv
// Directed self-checking bench for accel_sequencer; the bench plays both the
// bus front-end and the MAC array.
`timescale 1ns/1ps
module tb_accel_sequencer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        wr_en_push = 1'b0;
  logic        is_weight = 1'b0;
  logic [63:0] write_data = 64'd0;
  logic [7:0]  ctrl_reg = 8'h00;
  logic        handshake = 1'b0;
  logic        arr_out_valid = 1'b0;
  logic [63:0] arr_out_data = 64'd0;
  logic        w_load;
  logic [2:0]  w_row;
  logic [63:0] w_data;
  logic        arr_in_valid;
  logic [63:0] arr_in_data;
  logic [63:0] output_data;
  logic [7:0]  status_reg;
  logic [15:0] err_reg;
`ifdef ACCEL_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int issue_cnt = 0;
  int base;
  logic [63:0] iss_data [32];
  logic [4:0]  vpat;

  always #5 clk = ~clk;

  accel_sequencer dut (
    .clk(clk), .n_rst(n_rst), .wr_en_push(wr_en_push), .is_weight(is_weight),
    .write_data(write_data), .ctrl_reg(ctrl_reg), .handshake(handshake),
    .arr_out_valid(arr_out_valid), .arr_out_data(arr_out_data),
    .w_load(w_load), .w_row(w_row), .w_data(w_data),
    .arr_in_valid(arr_in_valid), .arr_in_data(arr_in_data),
    .output_data(output_data), .status_reg(status_reg), .err_reg(err_reg)
`ifdef ACCEL_SEQ_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // Record every row the sequencer hands to the array.
  always @(posedge clk) begin
    if (arr_in_valid && issue_cnt < 32) begin
      iss_data[issue_cnt] <= arr_in_data;
      issue_cnt <= issue_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic w, input logic [63:0] d);
    wr_en_push = 1'b1;
    is_weight  = w;
    write_data = d;
    tick();
    wr_en_push = 1'b0;
    is_weight  = 1'b0;
  endtask

  task automatic load_weights();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'(i + 1);
      push_row(1'b1, {8{b}});
      check_eq("w_load", 64'(w_load), 64'd1);
      check_eq("w_row", 64'(w_row), 64'(i));
      check_eq("w_data", w_data, {8{b}});
    end
  endtask

  task automatic return_result(input logic [63:0] d);
    arr_out_valid = 1'b1;
    arr_out_data  = d;
    tick();
    arr_out_valid = 1'b0;
    arr_out_data  = 64'd0;
  endtask

  task automatic pulse_ctrl(input logic [7:0] v);
    ctrl_reg = v;
    tick();
    ctrl_reg = 8'h00;
  endtask

  initial begin
    tick();
    tick();
    check_eq("rst_w_load", 64'(w_load), 64'd0);
    check_eq("rst_arr_in_valid", 64'(arr_in_valid), 64'd0);
    check_eq("rst_output_data", output_data, 64'd0);
    check_eq("rst_status", 64'(status_reg), 64'h00);
    check_eq("rst_err", 64'(err_reg), 64'h0000);
    n_rst = 1'b1;

    // Full weight load
    load_weights();
    tick();
    check_eq("status_loaded", 64'(status_reg), 64'h54);

    // Three inputs, start, three results, three pops
    push_row(1'b0, 64'hA1A1_A1A1_A1A1_A1A1);
    push_row(1'b0, 64'hA2A2_A2A2_A2A2_A2A2);
    push_row(1'b0, 64'hA3A3_A3A3_A3A3_A3A3);
    base = issue_cnt;
    pulse_ctrl(8'h01);
    vpat = 5'b00000;
    for (int c = 0; c < 5; c++) begin
      tick();
      vpat = {vpat[3:0], arr_in_valid};
    end
    check_eq("issue_pattern", 64'(vpat), 64'h1C);
    check_eq("issue0", iss_data[base], 64'hA1A1_A1A1_A1A1_A1A1);
    check_eq("issue2", iss_data[base + 2], 64'hA3A3_A3A3_A3A3_A3A3);
    return_result(64'h0000_0000_0000_00C1);
    return_result(64'h0000_0000_0000_00C2);
    return_result(64'h0000_0000_0000_00C3);
    check_eq("out_head", output_data, 64'h0000_0000_0000_00C1);
    tick();
    check_eq("status_out_valid", 64'(status_reg[0]), 64'd1);
    handshake = 1'b1;
    tick();
    check_eq("pop1", output_data, 64'h0000_0000_0000_00C2);
    tick();
    check_eq("pop2", output_data, 64'h0000_0000_0000_00C3);
    tick();
    handshake = 1'b0;
    check_eq("pop3_empty", output_data, 64'd0);
    tick();
    check_eq("status_back_ready", 64'(status_reg), 64'h54);
    check_eq("err_clean", 64'(err_reg), 64'h0000);

    // Credit limit: six inputs, only four issue until results are popped
    for (int k = 1; k <= 6; k++) push_row(1'b0, {8{8'(8'hB0 + 8'(k))}});
    base = issue_cnt;
    pulse_ctrl(8'h01);
    for (int c = 0; c < 8; c++) tick();
    check_eq("credit_issue4", 64'(issue_cnt - base), 64'd4);
    for (int k = 1; k <= 4; k++) return_result({8{8'(8'hD0 + 8'(k))}});
    for (int c = 0; c < 4; c++) tick();
    check_eq("credit_hold4", 64'(issue_cnt - base), 64'd4);
    check_eq("credit_status", 64'(status_reg[1:0]), 64'd3);
    handshake = 1'b1;
    tick();
    tick();
    handshake = 1'b0;
    check_eq("credit_head", output_data, 64'hD3D3_D3D3_D3D3_D3D3);
    for (int c = 0; c < 6; c++) tick();
    check_eq("credit_issue6", 64'(issue_cnt - base), 64'd6);
    check_eq("credit_issue5_data", iss_data[base + 4], 64'hB5B5_B5B5_B5B5_B5B5);
    check_eq("credit_issue6_data", iss_data[base + 5], 64'hB6B6_B6B6_B6B6_B6B6);
    return_result(64'hD5D5_D5D5_D5D5_D5D5);
    return_result(64'hD6D6_D6D6_D6D6_D6D6);
    for (int c = 0; c < 3; c++) tick();
    check_eq("credit_done_status", 64'(status_reg), 64'h55);

    // Input overflow, then clear
    for (int k = 0; k < 9; k++) push_row(1'b0, {8{8'(8'hE0 + 8'(k))}});
    check_eq("in_ovf_err", 64'(err_reg), 64'h0001);
    tick();
    check_eq("in_full_status", 64'(status_reg), 64'h4D);
    pulse_ctrl(8'h02);
    check_eq("clear_err", 64'(err_reg), 64'h0000);
    check_eq("clear_output", output_data, 64'd0);
    tick();
    check_eq("clear_status", 64'(status_reg), 64'h10);

    // Handshake on empty result FIFO, start edge while IDLE
    handshake = 1'b1;
    tick();
    handshake = 1'b0;
    check_eq("hs_empty_err", 64'(err_reg), 64'h0002);
    pulse_ctrl(8'h01);
    check_eq("start_idle_err", 64'(err_reg), 64'h0202);
    tick();
    check_eq("start_idle_status", 64'(status_reg), 64'h10);
    pulse_ctrl(8'h02);

    // Clear with two rows in flight: late results are discarded
    load_weights();
    tick();
    push_row(1'b0, 64'h1111_1111_1111_1111);
    push_row(1'b0, 64'h2222_2222_2222_2222);
    pulse_ctrl(8'h01);
    for (int c = 0; c < 3; c++) tick();
    pulse_ctrl(8'h02);
    return_result(64'h3333_3333_3333_3333);
    return_result(64'h4444_4444_4444_4444);
    tick();
    check_eq("drain_output", output_data, 64'd0);
    check_eq("drain_status", 64'(status_reg), 64'h10);
    check_eq("drain_err", 64'(err_reg), 64'h0000);

    // Weight push during COMPUTE, then reset mid-COMPUTE
    load_weights();
    tick();
    for (int k = 0; k < 4; k++) push_row(1'b0, {8{8'(8'h50 + 8'(k))}});
    pulse_ctrl(8'h01);
    push_row(1'b1, 64'h7777_7777_7777_7777);
    check_eq("w_in_compute_load", 64'(w_load), 64'd0);
    check_eq("w_in_compute_err", 64'(err_reg), 64'h0100);
    check_eq("compute_issuing", 64'(arr_in_valid), 64'd1);
    n_rst = 1'b0;
    tick();
    check_eq("mid_rst_w_load", 64'(w_load), 64'd0);
    check_eq("mid_rst_w_row", 64'(w_row), 64'd0);
    check_eq("mid_rst_w_data", w_data, 64'd0);
    check_eq("mid_rst_arr_in_valid", 64'(arr_in_valid), 64'd0);
    check_eq("mid_rst_arr_in_data", arr_in_data, 64'd0);
    check_eq("mid_rst_output", output_data, 64'd0);
    check_eq("mid_rst_status", 64'(status_reg), 64'h00);
    check_eq("mid_rst_err", 64'(err_reg), 64'h0000);
    n_rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("post_rst_no_issue", 64'(arr_in_valid), 64'd0);
    end
    check_eq("post_rst_status", 64'(status_reg), 64'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
